// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the IF/DM memory port arbiter.
package rvcore_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned streak_w(input int unsigned max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

  // Timer only ever holds 0..TIMEOUT-1 before the forced completion.
  function automatic int unsigned timer_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner select for the shared bus: DM first, IF forced after a streak of DM wins.
module mem_arb_prio
  import rvcore_mem_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic issue_i,
  output logic grant_if_o,
  output logic grant_dm_o
);

  localparam int unsigned SW = streak_w(MAX_DM_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          if_turn;

  always_comb begin
    if_turn    = if_req_i && (!dm_req_i || (streak_q == STREAK_MAX));
    grant_if_o = issue_i && if_turn;
    grant_dm_o = issue_i && dm_req_i && !if_turn;
    streak_d   = streak_q;
    if (grant_if_o) begin
      streak_d = '0;
    end else if (grant_dm_o && if_req_i && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding bus shared by instruction fetch and load/store, with flush drop and timeout.
module mem_port_arbiter
  import rvcore_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_flush,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_strb,
  output logic                o_dm_rvalid,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic [DATA_W/8-1:0] o_bus_strb,
  input  logic                i_bus_gnt,
  input  logic                i_bus_rvalid,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  output logic                o_bus_err,
  output logic                o_idle
);

  localparam int unsigned SW = strb_w(DATA_W);
  localparam int unsigned TW = timer_w(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            drop_q, drop_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]   strb_q, strb_d;

  logic            if_req_live, issue, grant_if, grant_dm;
  logic            timeout_hit, complete;
  logic [DATA_W-1:0] resp_data;

  // A flush in IDLE kills the same-cycle fetch before it can win arbitration.
  assign if_req_live = i_if_req && !i_flush;
  assign issue       = (state_q == IDLE);

  mem_arb_prio #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .if_req_i  (if_req_live),
    .dm_req_i  (i_dm_req),
    .issue_i   (issue),
    .grant_if_o(grant_if),
    .grant_dm_o(grant_dm)
  );

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (state_q == WAIT) && !i_bus_rvalid
                  && (timer_q == TIMER_LAST);
    complete    = (state_q == WAIT) && (i_bus_rvalid || timeout_hit);
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    timer_d = timer_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d = REQ;
          owner_d = OWN_DM;
          drop_d  = 1'b0;
          we_d    = i_dm_we;
          addr_d  = i_dm_addr;
          wdata_d = i_dm_wdata;
          strb_d  = i_dm_strb;
        end else if (grant_if) begin
          state_d = REQ;
          owner_d = OWN_IF;
          drop_d  = 1'b0;
          we_d    = 1'b0;
          addr_d  = i_if_addr;
          wdata_d = '0;
          strb_d  = '0;
        end
      end
      REQ: begin
        if (i_bus_gnt) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (complete) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && (owner_q == OWN_IF) && i_flush) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    resp_data   = timeout_hit ? '0 : i_bus_rdata;
    o_dm_rvalid = complete && (owner_q == OWN_DM);
    o_if_rvalid = complete && (owner_q == OWN_IF) && !drop_q && !i_flush;
    o_dm_rdata  = o_dm_rvalid ? resp_data : '0;
    o_if_rdata  = o_if_rvalid ? resp_data : '0;
  end

  assign o_bus_req   = (state_q == REQ);
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_bus_strb  = strb_q;
  assign o_bus_err   = timeout_hit;
  assign o_idle      = (state_q == IDLE);

endmodule
